// File: rtl/demux_pkg.sv
// demux_pkg: shared buffer-state encoding, counter width and select codes for demux_stream
package demux_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;
  localparam int   CNT_W    = 16;
  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;
endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: one valid/ready input stream with per-beat select, two valid/ready output streams
interface demux_stream_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              sel;
  logic              in_ready;
  logic              out1_valid;
  logic [DATA_W-1:0] out1_data;
  logic              out1_ready;
  logic              out2_valid;
  logic [DATA_W-1:0] out2_data;
  logic              out2_ready;
  modport master (
    output in_valid, in_data, sel, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data
  );
  modport slave (
    input  in_valid, in_data, sel, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data
  );
endinterface

// File: rtl/demux_fifo2.sv
// demux_fifo2: 2-entry FIFO with a registered head entry, tracked as EMPTY/ONE/FULL
module demux_fifo2
  import demux_pkg::*;
#(parameter int DATA_W = 8) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full
);
  buf_state_t        r_state;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic              w_push;
  logic              w_pop;
  assign w_push  = i_push & (r_state != FULL);
  assign w_pop   = i_pop & (r_state != EMPTY);
  assign o_data  = r_head;
  assign o_valid = r_state != EMPTY;
  assign o_full  = r_state == FULL;
  // Occupancy FSM; head is always the oldest beat, tail only holds the second one
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) begin
          r_state <= ONE;
          r_head  <= i_data;
        end
        ONE: if (w_push && w_pop) begin
          r_head <= i_data;
        end else if (w_push) begin
          r_state <= FULL;
          r_tail  <= i_data;
        end else if (w_pop) begin
          r_state <= EMPTY;
        end
        FULL: if (w_pop) begin
          r_state <= ONE;
          r_head  <= r_tail;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demux with a 2-entry buffer per output; DEMUX_CNT_EN adds delivery counters
module demux_stream
  import demux_pkg::*;
#(parameter int DATA_W = 8) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  demux_stream_if.slave    bus
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);
  logic w_full1;
  logic w_full2;
  logic w_accept;
  logic w_push1;
  logic w_push2;
  logic w_pop1;
  logic w_pop2;
  // Readiness depends only on the selected buffer, so a full neighbour never blocks
  assign bus.in_ready = (bus.sel == SEL_OUT2) ? !w_full2 : !w_full1;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_push1      = w_accept & (bus.sel == SEL_OUT1);
  assign w_push2      = w_accept & (bus.sel == SEL_OUT2);
  assign w_pop1       = bus.out1_valid & bus.out1_ready;
  assign w_pop2       = bus.out2_valid & bus.out2_ready;
  demux_fifo2 #(.DATA_W(DATA_W)) u_fifo1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_push    (w_push1),
    .i_data    (bus.in_data),
    .i_pop     (w_pop1),
    .o_data    (bus.out1_data),
    .o_valid   (bus.out1_valid),
    .o_full    (w_full1)
  );
  demux_fifo2 #(.DATA_W(DATA_W)) u_fifo2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_push    (w_push2),
    .i_data    (bus.in_data),
    .i_pop     (w_pop2),
    .o_data    (bus.out2_data),
    .o_valid   (bus.out2_valid),
    .o_full    (w_full2)
  );
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_cnt2;
  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;
  // Delivered-beat counters, free-running with natural wrap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else begin
      r_cnt1 <= w_pop1 ? r_cnt1 + CNT_W'(1) : r_cnt1;
      r_cnt2 <= w_pop2 ? r_cnt2 + CNT_W'(1) : r_cnt2;
    end
  end
`endif
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: table vectors, hand sequences and random traffic against a queue model of demux_stream
module tb_demux_stream;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int c1 = 0;
  int c2 = 0;
  logic last_acc = 1'b0;
  demux_stream_if #(.DATA_W(8)) bus ();
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
  demux_stream #(.DATA_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus), .cnt1(cnt1), .cnt2(cnt2)
  );
`else
  demux_stream #(.DATA_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );
`endif
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic       r1;
    logic       r2;
    logic       e_ir;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_v2;
    logic [7:0] e_d2;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r1, input logic r2);
    bus.in_valid = v;
    bus.sel = s;
    bus.in_data = d;
    bus.out1_ready = r1;
    bus.out2_ready = r2;
  endtask

  // Check outputs against the queue model, then advance the model across one clock edge
  task automatic step();
    int n1;
    int n2;
    logic e_ir;
    logic p1;
    logic p2;
    logic acc;
    logic s;
    logic [7:0] d;
    #1;
    n1 = q1.size();
    n2 = q2.size();
    e_ir = bus.sel ? (n2 < 2) : (n1 < 2);
    check("in_ready", bus.in_ready, e_ir);
    check("out1_valid", bus.out1_valid, n1 > 0);
    check("out2_valid", bus.out2_valid, n2 > 0);
    if (n1 > 0) check("out1_data", bus.out1_data, q1[0]);
    if (n2 > 0) check("out2_data", bus.out2_data, q2[0]);
`ifdef DEMUX_CNT_EN
    check("cnt1", cnt1, c1);
    check("cnt2", cnt2, c2);
`endif
    p1 = (n1 > 0) && bus.out1_ready;
    p2 = (n2 > 0) && bus.out2_ready;
    acc = bus.in_valid && e_ir;
    s = bus.sel;
    d = bus.in_data;
    @(posedge sys_clk);
    if (p1) begin
      void'(q1.pop_front());
      c1 = (c1 + 1) % 65536;
    end
    if (p2) begin
      void'(q2.pop_front());
      c2 = (c2 + 1) % 65536;
    end
    if (acc) begin
      if (s) q2.push_back(d);
      else q1.push_back(d);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out1_valid"}, bus.out1_valid, 1'b0);
    check({tag, "_out2_valid"}, bus.out2_valid, 1'b0);
    check({tag, "_out1_data"}, bus.out1_data, 8'h00);
    check({tag, "_out2_data"}, bus.out2_data, 8'h00);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
`ifdef DEMUX_CNT_EN
    check({tag, "_cnt1"}, cnt1, 16'h0000);
    check({tag, "_cnt2"}, cnt2, 16'h0000);
`endif
  endtask

  vec_t tab[11];

  initial begin
    tab[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tab[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
    tab[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
    tab[3]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tab[4]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    tab[5]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00};
    tab[6]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    tab[7]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h77};
    tab[8]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    tab[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    tab[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1;
    check_cleared("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    repeat (2) step();

    for (int i = 0; i < 11; i++) begin
      drive(tab[i].v, tab[i].s, tab[i].d, tab[i].r1, tab[i].r2);
      #1;
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, tab[i].e_ir);
      check($sformatf("vec%0d_out1_valid", i), bus.out1_valid, tab[i].e_v1);
      check($sformatf("vec%0d_out2_valid", i), bus.out2_valid, tab[i].e_v2);
      if (tab[i].e_v1) check($sformatf("vec%0d_out1_data", i), bus.out1_data, tab[i].e_d1);
      if (tab[i].e_v2) check($sformatf("vec%0d_out2_data", i), bus.out2_data, tab[i].e_d2);
      step();
    end
`ifdef DEMUX_CNT_EN
    check("vec_cnt1_total", cnt1, 16'd4);
    check("vec_cnt2_total", cnt2, 16'd2);
`endif

    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'h12, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 8'h21, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 8'h23, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    #1;
    check("full_in_ready_sel0", bus.in_ready, 1'b0);
    check("full_out1_data", bus.out1_data, 8'h11);
    check("full_out2_data", bus.out2_data, 8'h21);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    q1.delete();
    q2.delete();
    c1 = 0;
    c2 = 0;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    repeat (3) step();
    check_cleared("post_rst");

    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic s;
      logic [7:0] d;
      if (bus.in_valid && !last_acc) begin
        v = 1'b1;
        d = bus.in_data;
        s = ($urandom_range(0, 3) == 0) ? ~bus.sel : bus.sel;
      end else begin
        v = $urandom_range(0, 3) != 0;
        s = $urandom_range(0, 1) == 1;
        d = 8'($urandom);
      end
      drive(v, s, d, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
